// File: rtl/sc_rand_pkg.sv
// Shared definitions for the random-delay block: FSM state encoding and default minimum delay.
package sc_rand_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DefaultMinDelay = 4;

endpackage

// File: rtl/sc_rand_delay_if.sv
// Handshake bundle between the random-delay block and the logic that requests delays.
interface sc_rand_delay_if #(
  parameter int unsigned RandDELAY_DATAWIDTH = 8
);

  logic [RandDELAY_DATAWIDTH-1:0] SC_RandDELAY_random_InBUS;
  logic                           SC_RandDELAY_start_In;
  logic                           SC_RandDELAY_tick_In;
  logic                           SC_RandDELAY_abort_In;
  logic                           SC_RandDELAY_busy_Out;
  logic                           SC_RandDELAY_done_Out;
  logic [RandDELAY_DATAWIDTH:0]   SC_RandDELAY_count_OutBUS;

  modport master (
    output SC_RandDELAY_random_InBUS,
    output SC_RandDELAY_start_In,
    output SC_RandDELAY_tick_In,
    output SC_RandDELAY_abort_In,
    input  SC_RandDELAY_busy_Out,
    input  SC_RandDELAY_done_Out,
    input  SC_RandDELAY_count_OutBUS
  );

  modport slave (
    input  SC_RandDELAY_random_InBUS,
    input  SC_RandDELAY_start_In,
    input  SC_RandDELAY_tick_In,
    input  SC_RandDELAY_abort_In,
    output SC_RandDELAY_busy_Out,
    output SC_RandDELAY_done_Out,
    output SC_RandDELAY_count_OutBUS
  );

endinterface

// File: rtl/sc_rand_downcounter.sv
// Loadable down-counter with clear, decrement enable and an is-one flag for the final tick.
module sc_rand_downcounter #(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  input  logic             clr,
  output logic [Width-1:0] count,
  output logic             is_one
);

  logic [Width-1:0] count_q, count_d;

  // Clear beats load beats decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == Width'(1));

endmodule

// File: rtl/sc_rand_delay.sv
// Random delay generator: loads random+min into a down-counter on start, counts ticks, pulses done.
module sc_rand_delay
  import sc_rand_pkg::*;
#(
  parameter int unsigned RandDELAY_DATAWIDTH = 8,
  parameter int unsigned RandDELAY_MIN_DELAY = DefaultMinDelay
) (
  input  logic          SC_RandDELAY_CLOCK_50,
  input  logic          SC_RandDELAY_RESET_InHigh,
  sc_rand_delay_if.slave bus
);

  localparam int unsigned CntWidth = RandDELAY_DATAWIDTH + 1;

  state_e              state_q, state_d;
  logic                cnt_load, cnt_dec, cnt_clr, cnt_is_one;
  logic [CntWidth-1:0] cnt_value;
  logic [CntWidth-1:0] load_value;

  // Extra bit keeps random+min from wrapping.
  assign load_value = {1'b0, bus.SC_RandDELAY_random_InBUS} + CntWidth'(RandDELAY_MIN_DELAY);

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.SC_RandDELAY_start_In) begin
          cnt_load = 1'b1;
          state_d  = StCount;
        end
      end
      StCount: begin
        // Abort takes priority over a coincident final tick.
        if (bus.SC_RandDELAY_abort_In) begin
          cnt_clr = 1'b1;
          state_d = StIdle;
        end else if (bus.SC_RandDELAY_tick_In) begin
          cnt_dec = 1'b1;
          if (cnt_is_one) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge SC_RandDELAY_CLOCK_50) begin
    if (SC_RandDELAY_RESET_InHigh) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  sc_rand_downcounter #(
    .Width(CntWidth)
  ) u_downcounter (
    .clk        (SC_RandDELAY_CLOCK_50),
    .rst        (SC_RandDELAY_RESET_InHigh),
    .load       (cnt_load),
    .load_value (load_value),
    .dec        (cnt_dec),
    .clr        (cnt_clr),
    .count      (cnt_value),
    .is_one     (cnt_is_one)
  );

  assign bus.SC_RandDELAY_busy_Out     = (state_q == StCount);
  assign bus.SC_RandDELAY_done_Out     = (state_q == StDone);
  assign bus.SC_RandDELAY_count_OutBUS = cnt_value;

endmodule
